// File: rtl/two_bit_counter_decoder_if.sv
// Observation bus between a two-bit counter and its decoder/checker.
// Carries sampled counter state, wrap flag, error clear and decoded results.
interface two_bit_counter_decoder_if #(
  parameter int unsigned WRAP_W = 8
);
  logic              a;
  logic              b;
  logic              z;
  logic              err_clr;
  logic              x_dec;
  logic              x_valid;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              illegal;
  logic              z_mismatch;
  logic              err_seen;
  logic              in_sync;

  modport master (
    output a, b, z, err_clr,
    input  x_dec, x_valid, wrap_cnt,
    input  illegal, z_mismatch,
    input  err_seen, in_sync
  );

  modport slave (
    input  a, b, z, err_clr,
    output x_dec, x_valid, wrap_cnt,
    output illegal, z_mismatch,
    output err_seen, in_sync
  );
endinterface

// File: rtl/two_bit_counter_decoder.sv
// Checker beside a two-bit counter: recovers x from state steps,
// counts wraps, flags illegal jumps and inconsistent z.
module two_bit_counter_decoder #(
  parameter int unsigned WRAP_W     = 8,
  parameter int unsigned RESYNC_LEN = 4
) (
  input logic clk,
  input logic reset,
  two_bit_counter_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [3:0] RUN_END = 4'(RESYNC_LEN);

  state_t            state;
  logic [1:0]        prev_state;
  logic              prev_z;
  logic [3:0]        run;
  logic              x_dec_q;
  logic              x_valid_q;
  logic [WRAP_W-1:0] wrap_q;
  logic              illegal_q;
  logic              zm_q;
  logic              err_q;
  logic              sync_q;

  logic [1:0] s;
  logic [1:0] inc;
  logic       x;
  logic       legal;
  logic       exp_z;
  logic       mism;
  logic       set_ill;
  logic       set_zm;
  logic       err_n;
  logic       wrap_ev;
  logic       run_done;

  // Classify the step from the last sample to this one.
  always_comb begin
    s        = {bus.a, bus.b};
    inc      = prev_state + 2'd1;
    x        = (s == inc);
    legal    = (s == prev_state) | x;
    exp_z    = x & (prev_state == 2'b11);
    mism     = legal & (prev_z != exp_z);
    set_ill  = (state != SYNC) & ~legal;
    set_zm   = (state == TRACK) & mism;
    wrap_ev  = (state == TRACK) & exp_z
             & (wrap_q != '1);
    run_done = (run + 4'd1) == RUN_END;
    err_n    = err_q;
    if (bus.err_clr) err_n = 1'b0;
    if (set_ill | set_zm) err_n = 1'b1;
  end

  // Tracking FSM with all observable outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SYNC;
      prev_state <= 2'b00;
      prev_z     <= 1'b0;
      run        <= 4'd0;
      x_dec_q    <= 1'b0;
      x_valid_q  <= 1'b0;
      wrap_q     <= '0;
      illegal_q  <= 1'b0;
      zm_q       <= 1'b0;
      err_q      <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      prev_state <= s;
      prev_z     <= bus.z;
      illegal_q  <= set_ill;
      zm_q       <= set_zm;
      err_q      <= err_n;
      if (wrap_ev) wrap_q <= wrap_q + WRAP_W'(1);
      unique case (state)
        SYNC: begin
          state     <= TRACK;
          sync_q    <= 1'b1;
          x_valid_q <= 1'b0;
        end
        TRACK: begin
          if (legal) begin
            x_dec_q   <= x;
            x_valid_q <= 1'b1;
          end else begin
            state     <= FAULT;
            sync_q    <= 1'b0;
            x_valid_q <= 1'b0;
            run       <= 4'd0;
          end
        end
        FAULT: begin
          x_valid_q <= 1'b0;
          if (!legal) begin
            run <= 4'd0;
          end else if (run_done) begin
            run    <= 4'd0;
            state  <= TRACK;
            sync_q <= 1'b1;
          end else begin
            run <= run + 4'd1;
          end
        end
        default: begin
          state  <= SYNC;
          sync_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_dec      = x_dec_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.wrap_cnt   = wrap_q;
  assign bus.illegal    = illegal_q;
  assign bus.z_mismatch = zm_q;
  assign bus.err_seen   = err_q;
  assign bus.in_sync    = sync_q;

endmodule
